bt656_encode: RTL and testbench
===============================

BT656_ENCODE -- requirements
Module: bt656_encode

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1440, active words per line (even, Cb Y Cr Y order).
REQ-002 SHALL have parameter H_BLANK, default 268, blanking words between the EAV and SAV codes (even).
REQ-003 SHALL have port user_clk, input, 1, 27 MHz word clock; all flops clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1, run enable; when low, timing is held at frame start.
REQ-006 SHALL have port din, input, 8, 4:2:2 active video word, sampled when pix_req is high.
REQ-007 SHALL have port din_valid, input, 1, din valid qualifier.
REQ-008 SHALL have port pix_req, output, 1, requests one din word this cycle (combinational from counter registers and en).
REQ-009 SHALL have port dout, output, 8, registered BT.656 stream.
REQ-010 SHALL have ports h_o, v_o, f_o, output, 1 each, registered H/V/F flags aligned with dout.
REQ-011 SHALL have port frame_o, output, 1, registered one-cycle pulse aligned with the first EAV word of line 1.
REQ-012 SHALL have port underflow, output, 1, sticky flag for a missing pixel.

Function
REQ-013 Word counter hcnt SHALL run 0..L-1, with L = 8+H_BLANK+H_ACTIVE (default 1716), and wrap to 0.
REQ-014 Line counter SHALL run 1..525; it increments when hcnt wraps, and 525 wraps to 1.
REQ-015 F SHALL be 1 on lines 1-3 and 266-525, and 0 otherwise; V SHALL be 1 on lines 1-19 and 264-282, and 0 otherwise.
REQ-016 hcnt 0-3 SHALL produce EAV words FF,00,00,XY with H=1; hcnt 4+H_BLANK to 7+H_BLANK SHALL produce SAV words FF,00,00,XY with H=0.
REQ-017 XY SHALL be {1,F,V,H,V^H,F^H,F^V,F^V^H}.
REQ-018 Blanking words (hcnt 4..3+H_BLANK, and the active region of V=1 lines) SHALL be 0x80 for even hcnt and 0x10 for odd hcnt.
REQ-019 pix_req SHALL be high iff en=1, V=0, and hcnt is in 8+H_BLANK..L-1; it SHALL be asserted exactly H_ACTIVE times per active line.
REQ-020 Latency: din sampled in cycle t with pix_req=1 SHALL appear on dout in cycle t+1.
REQ-021 Active words SHALL be clipped: 0x00 becomes 0x01, 0xFF becomes 0xFE, other values pass unchanged.
REQ-022 If pix_req=1 and din_valid=0, dout SHALL carry the blanking value for that hcnt parity, and underflow SHALL set.
REQ-023 h_o, v_o and f_o SHALL reflect the H (1 in EAV and blanking, 0 in SAV and active), V and F of the word currently on dout.
REQ-024 While en=0, counters SHALL hold line 1, hcnt 0; dout=0x10, pix_req=0, frame_o=0, and underflow SHALL be cleared.
REQ-025 On the first edge with en=1, dout SHALL become 0xFF, frame_o=1, and hcnt SHALL advance to 1.
REQ-026 If en falls mid-line, then on the next edge counters SHALL return to line 1, hcnt 0, and dout SHALL be 0x10; pix_req SHALL drop in the same cycle en is low.
REQ-027 One frame SHALL be 525*L cycles (900,900 at default) and SHALL contain 487 active lines.

Reset
REQ-028 While rst is high, SHALL hold line=1, hcnt=0, dout=0x10, h_o=1, v_o=1, f_o=1, frame_o=0, underflow=0, pix_req=0.
REQ-029 Release of rst SHALL have no effect until en=1; a rst assertion mid-frame SHALL abort immediately and restart at line 1.

Verification
REQ-030 Reset, then en=1 -> dout = FF,00,00,F1, then 268 words alternating 80,10, then FF,00,00,EC; frame_o high on the first FF only.
REQ-031 Run to line 20 -> EAV XY=9D, SAV XY=80, 1440 pix_req cycles; a din ramp of 00..FF appears one cycle later as 01..FE (clipped).
REQ-032 Lines 264 and 283 -> EAV/SAV XY = B6/AB and DA/C7 respectively; no pix_req on line 264.
REQ-033 Hold din_valid=0 for one pix_req cycle at an odd hcnt -> dout=0x10 in the next cycle, underflow=1 and stays set; en low clears it.
REQ-034 Full frame with en=1 -> 900,900 cycles between frame_o pulses and 701,280 pix_req cycles.
REQ-035 Drop en at line 100, hcnt 500 -> next cycle dout=0x10 and pix_req=0; re-raise en -> FF,00,00,F1 restarts.

Source files
------------

// File: rtl/bt656_encode.sv
// BT.656 4:2:2 stream encoder: EAV/SAV timing codes, blanking fill,
// active-video clipping and one-cycle pixel pull from an upstream source.
module bt656_encode #(
  parameter int H_ACTIVE = 1440,
  parameter int H_BLANK  = 268
) (
  input  logic       user_clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       pix_req,
  output logic [7:0] dout,
  output logic       h_o,
  output logic       v_o,
  output logic       f_o,
  output logic       frame_o,
  output logic       underflow
);

  localparam int L  = 8 + H_BLANK + H_ACTIVE;
  localparam int HW = $clog2(L);

  localparam logic [HW-1:0] H_LAST = HW'(L - 1);
  localparam logic [HW-1:0] SAV0   = HW'(4 + H_BLANK);
  localparam logic [HW-1:0] ACT0   = HW'(8 + H_BLANK);
  localparam logic [HW-1:0] EAV_N  = HW'(4);
  localparam logic [HW-1:0] H_ONE  = HW'(1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [9:0]    line_q, line_d;
  logic [7:0]    dout_q, dout_d;
  logic          h_q, h_d;
  logic          v_q, v_d;
  logic          f_q, f_d;
  logic          frame_q, frame_d;
  logic          uf_q, uf_d;

  logic          f_c, v_c;
  logic          in_eav, in_blank, in_sav, in_act;
  logic [HW-1:0] sav_off;
  logic [7:0]    blank_w;

  function automatic logic [7:0] xy(input logic f, input logic v,
                                    input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [7:0] code(input logic [1:0] idx,
                                      input logic [7:0] w);
    logic [7:0] r;
    unique case (idx)
      2'd0:    r = 8'hFF;
      2'd3:    r = w;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] clip(input logic [7:0] w);
    logic [7:0] r;
    unique case (w)
      8'h00:   r = 8'h01;
      8'hFF:   r = 8'hFE;
      default: r = w;
    endcase
    return r;
  endfunction

  assign f_c = (line_q <= 10'd3) || (line_q >= 10'd266);
  assign v_c = (line_q <= 10'd19) ||
               ((line_q >= 10'd264) && (line_q <= 10'd282));

  assign in_eav   = hcnt_q < EAV_N;
  assign in_blank = !in_eav && (hcnt_q < SAV0);
  assign in_sav   = (hcnt_q >= SAV0) && (hcnt_q < ACT0);
  assign in_act   = hcnt_q >= ACT0;

  assign sav_off  = hcnt_q - SAV0;
  assign blank_w  = hcnt_q[0] ? 8'h10 : 8'h80;

  assign pix_req  = en && !v_c && in_act;

  always_comb begin
    hcnt_d  = hcnt_q;
    line_d  = line_q;
    dout_d  = 8'h10;
    h_d     = 1'b1;
    v_d     = 1'b1;
    f_d     = 1'b1;
    frame_d = 1'b0;
    uf_d    = 1'b0;
    if (!en) begin
      hcnt_d = '0;
      line_d = 10'd1;
    end else begin
      frame_d = (hcnt_q == '0) && (line_q == 10'd1);
      uf_d    = uf_q || (pix_req && !din_valid);
      v_d     = v_c;
      f_d     = f_c;
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        line_d = (line_q == 10'd525) ? 10'd1 : line_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + H_ONE;
      end
      unique case (1'b1)
        in_eav: begin
          h_d    = 1'b1;
          dout_d = code(hcnt_q[1:0], xy(f_c, v_c, 1'b1));
        end
        in_blank: begin
          h_d    = 1'b1;
          dout_d = blank_w;
        end
        in_sav: begin
          h_d    = 1'b0;
          dout_d = code(sav_off[1:0], xy(f_c, v_c, 1'b0));
        end
        in_act: begin
          h_d    = 1'b0;
          // V lines and starved requests both fill with blanking
          dout_d = (pix_req && din_valid) ? clip(din) : blank_w;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge user_clk or posedge rst) begin
    if (rst) begin
      hcnt_q  <= '0;
      line_q  <= 10'd1;
      dout_q  <= 8'h10;
      h_q     <= 1'b1;
      v_q     <= 1'b1;
      f_q     <= 1'b1;
      frame_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      line_q  <= line_d;
      dout_q  <= dout_d;
      h_q     <= h_d;
      v_q     <= v_d;
      f_q     <= f_d;
      frame_q <= frame_d;
      uf_q    <= uf_d;
    end
  end

  assign dout      = dout_q;
  assign h_o       = h_q;
  assign v_o       = v_q;
  assign f_o       = f_q;
  assign frame_o   = frame_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_bt656_encode.sv
// Directed bench for bt656_encode using a short line (8 active, 4 blank)
// so full 525-line frames stay cheap to simulate.
module tb_bt656_encode;

  localparam int HA    = 8;
  localparam int HB    = 4;
  localparam int L     = 8 + HB + HA;
  localparam int FRAME = 525 * L;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       pix_req;
  logic [7:0] dout;
  logic       h_o, v_o, f_o, frame_o, underflow;

  int total = 0;
  int bad = 0;
  int n = 0;

  logic [7:0] seq1 [20] = '{
    8'hFF, 8'h00, 8'h00, 8'hF1, 8'h80, 8'h10, 8'h80, 8'h10,
    8'hFF, 8'h00, 8'h00, 8'hEC, 8'h80, 8'h10, 8'h80, 8'h10,
    8'h80, 8'h10, 8'h80, 8'h10};
  logic [7:0] ramp_in [8] = '{
    8'h00, 8'hFF, 8'h01, 8'hFE, 8'h7F, 8'h80, 8'h10, 8'hA5};
  logic [7:0] ramp_out [8] = '{
    8'h01, 8'hFE, 8'h01, 8'hFE, 8'h7F, 8'h80, 8'h10, 8'hA5};
  logic [7:0] first4 [4];

  bt656_encode #(.H_ACTIVE(HA), .H_BLANK(HB)) dut (
    .user_clk (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .din_valid(din_valid),
    .pix_req  (pix_req),
    .dout     (dout),
    .h_o      (h_o),
    .v_o      (v_o),
    .f_o      (f_o),
    .frame_o  (frame_o),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst || !en) n = 0;
    else n = (n + 1) % FRAME;
  endtask

  task automatic adv(input int l, input int h);
    int tgt;
    int g;
    tgt = (l - 1) * L + h;
    g = 0;
    while (n != tgt && g < FRAME) begin
      tick();
      g++;
    end
    if (n != tgt) chk("adv_timeout", n, tgt);
  endtask

  task automatic scan(input int l, output logic [7:0] eav,
                      output logic [7:0] sav, output int pc,
                      output logic [1:0] vf);
    adv(l, 0);
    pc = 0;
    eav = 8'h00;
    sav = 8'h00;
    vf = 2'b00;
    for (int k = 0; k < L; k++) begin
      if (pix_req) pc++;
      tick();
      if (k == 3) begin
        eav = dout;
        vf = {v_o, f_o};
      end
      if (k == 7 + HB) sav = dout;
    end
  endtask

  initial begin
    logic [7:0] e, s;
    logic [1:0] vf;
    int pc, cyc, p1, p2;

    tick();
    tick();
    chk("rst_dout", dout, 8'h10);
    chk("rst_hvf", {h_o, v_o, f_o}, 3'b111);
    chk("rst_frame", frame_o, 1'b0);
    chk("rst_uf", underflow, 1'b0);
    chk("rst_pixreq", pix_req, 1'b0);

    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("idle_dout", dout, 8'h10);
    chk("idle_frame", frame_o, 1'b0);

    en = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("line1_w%0d", k), dout, seq1[k]);
      chk($sformatf("line1_h%0d", k), h_o, (k < 8) ? 1'b1 : 1'b0);
      chk($sformatf("line1_fr%0d", k), frame_o, (k == 0) ? 1'b1 : 1'b0);
      chk($sformatf("line1_pr%0d", k), pix_req, 1'b0);
    end

    adv(20, 0);
    tick();
    chk("l20_eav0", dout, 8'hFF);
    adv(20, 4);
    chk("l20_eavxy", dout, 8'h9D);
    chk("l20_vf", {v_o, f_o}, 2'b00);
    adv(20, 11);
    chk("l20_pr_sav", pix_req, 1'b0);
    tick();
    chk("l20_savxy", dout, 8'h80);
    chk("l20_sav_h", h_o, 1'b0);
    din_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din = ramp_in[k];
      chk($sformatf("l20_pr%0d", k), pix_req, 1'b1);
      tick();
      chk($sformatf("l20_pix%0d", k), dout, ramp_out[k]);
    end
    chk("l21_pr_eav", pix_req, 1'b0);

    scan(22, e, s, pc, vf);
    chk("l22_eav", e, 8'h9D);
    chk("l22_sav", s, 8'h80);
    chk("l22_pix", pc, HA);

    adv(23, 12);
    din = 8'h55;
    tick();
    chk("uf_pre_dout", dout, 8'h55);
    chk("uf_pre_flag", underflow, 1'b0);
    din_valid = 1'b0;
    tick();
    chk("uf_dout", dout, 8'h10);
    chk("uf_set", underflow, 1'b1);
    din_valid = 1'b1;
    din = 8'h42;
    tick();
    chk("uf_post_dout", dout, 8'h42);
    chk("uf_sticky", underflow, 1'b1);

    scan(264, e, s, pc, vf);
    chk("l264_eav", e, 8'hB6);
    chk("l264_sav", s, 8'hAB);
    chk("l264_pix", pc, 0);
    chk("l264_vf", vf, 2'b10);

    scan(283, e, s, pc, vf);
    chk("l283_eav", e, 8'hDA);
    chk("l283_sav", s, 8'hC7);
    chk("l283_pix", pc, HA);
    chk("l283_vf", vf, 2'b01);

    scan(20, e, s, pc, vf);
    chk("f2_l20_pix", pc, HA);

    adv(100, 15);
    chk("drop_pr_before", pix_req, 1'b1);
    chk("drop_uf_before", underflow, 1'b1);
    en = 1'b0;
    #1;
    chk("drop_pr_comb", pix_req, 1'b0);
    tick();
    chk("drop_dout", dout, 8'h10);
    chk("drop_uf", underflow, 1'b0);
    chk("drop_frame", frame_o, 1'b0);
    chk("drop_h", h_o, 1'b1);

    en = 1'b1;
    n = 0;
    cyc = 0;
    p1 = -1;
    p2 = -1;
    pc = 0;
    for (int g = 0; g < 2 * FRAME + 4; g++) begin
      if (pix_req) pc++;
      tick();
      cyc++;
      if (cyc <= 4) first4[cyc-1] = dout;
      if (frame_o) begin
        if (p1 < 0) p1 = cyc;
        else begin
          p2 = cyc;
          break;
        end
      end
    end
    chk("restart_w0", first4[0], 8'hFF);
    chk("restart_w1", first4[1], 8'h00);
    chk("restart_w2", first4[2], 8'h00);
    chk("restart_w3", first4[3], 8'hF1);
    chk("frame_first", p1, 1);
    chk("frame_period", p2 - p1, FRAME);
    chk("frame_pix", pc, 487 * HA);

    adv(50, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dout", dout, 8'h10);
    chk("arst_hvf", {h_o, v_o, f_o}, 3'b111);
    chk("arst_pr", pix_req, 1'b0);
    tick();
    chk("arst_hold", dout, 8'h10);
    rst = 1'b0;
    tick();
    chk("arst_restart", dout, 8'hFF);
    chk("arst_frame", frame_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
